// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, round constants and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned NBYTES = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEXP,
    S_DEC,
    S_OUT
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

endpackage

// File: rtl/inv_sub_byte.sv
// Inverse S-box on a 32-bit word: inverse affine map, then GF(2^8) inverse.
module inv_sub_byte
  import aes_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Substitute each byte of the word independently.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      data_o[8*i +: 8] = inv_sbox(data_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/subByte.sv
// Forward S-box on a 32-bit word, used for SubWord in key expansion.
module subByte
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Substitute each byte of the word independently.
  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryption: byte-serial load, on-chip key expansion,
// one inverse round per enabled clock, byte-serial plaintext output.
module aes_decryption
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] key_byte,
  input  logic [7:0] state_byte,
  output logic [7:0] state_out_byte,
  output logic       load,
  output logic       ready
);

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   ct_q, ct_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   rk_q [0:NR];
  logic [7:0]     out_q, out_d;
  logic           load_q, load_d;
  logic           ready_q, ready_d;

  logic           rk_we;
  logic [3:0]     rk_widx;
  logic [127:0]   rk_wdata;

  logic [127:0]   rk_prev, rk_cur, rk_next;
  logic [31:0]    sw_out, kx_tmp;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   shifted, isb, added, mixed;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = s[127-32*((c+4-r)%4)-8*r -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Select round keys: previous one for expansion, current one for decryption.
  always_comb begin
    rk_prev = '0;
    rk_cur  = '0;
    for (int unsigned i = 0; i <= NR; i++) begin
      if (rnd_q == 4'(i))     rk_cur  = rk_q[i];
      if (rnd_q == 4'(i + 1)) rk_prev = rk_q[i];
    end
  end

  subByte u_subword (
    .word_i ({rk_prev[23:0], rk_prev[31:24]}),
    .word_o (sw_out)
  );

  // One step of the AES-128 key schedule.
  always_comb begin
    kx_tmp  = sw_out ^ {rcon(rnd_q), 24'h000000};
    n0      = rk_prev[127:96] ^ kx_tmp;
    n1      = rk_prev[95:64]  ^ n0;
    n2      = rk_prev[63:32]  ^ n1;
    n3      = rk_prev[31:0]   ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

  assign shifted = inv_shift_rows(st_q);

  for (genvar g = 0; g < 4; g++) begin : g_isb
    inv_sub_byte u_isb (
      .data_i (shifted[32*g +: 32]),
      .data_o (isb[32*g +: 32])
    );
  end

  // Inverse round datapath; InvMixColumns is bypassed on the final round.
  always_comb begin
    added = isb ^ rk_cur;
    mixed = inv_mix_columns(added);
  end

  // Next-state, datapath updates and round-key write request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    key_d    = key_q;
    ct_d     = ct_q;
    st_d     = st_q;
    out_d    = out_q;
    load_d   = load_q;
    ready_d  = ready_q;
    rk_we    = 1'b0;
    rk_widx  = '0;
    rk_wdata = '0;
    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
        load_d  = 1'b1;
        cnt_d   = '0;
      end
      S_LOAD: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (cnt_q == 5'(i)) begin
            key_d[127-8*i -: 8] = key_byte;
            ct_d[8*i +: 8]      = state_byte;
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(NBYTES - 1)) begin
          state_d  = S_KEXP;
          load_d   = 1'b0;
          rk_we    = 1'b1;
          rk_widx  = '0;
          rk_wdata = key_d;
          rnd_d    = 4'd1;
        end
      end
      S_KEXP: begin
        rk_we    = 1'b1;
        rk_widx  = rnd_q;
        rk_wdata = rk_next;
        if (rnd_q == 4'(NR)) begin
          state_d = S_DEC;
          st_d    = ct_q ^ rk_next;
          rnd_d   = 4'(NR - 1);
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DEC: begin
        if (rnd_q == 4'd0) begin
          st_d    = added;
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          st_d  = mixed;
          rnd_d = rnd_q - 4'd1;
        end
      end
      S_OUT: begin
        if (cnt_q == 5'(NBYTES)) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (cnt_q == 5'(i)) out_d = st_q[127-8*i -: 8];
          end
          ready_d = 1'b1;
          cnt_d   = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; everything holds while enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      st_q    <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      st_q    <= st_d;
      out_q   <= out_d;
      load_q  <= load_d;
      ready_q <= ready_d;
      if (rk_we) begin
        for (int unsigned i = 0; i <= NR; i++) begin
          if (rk_widx == 4'(i)) rk_q[i] <= rk_wdata;
        end
      end
    end
  end

  assign state_out_byte = out_q;
  assign load           = load_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption. Expected plaintexts come from FIPS-197
// vectors or from a forward AES-128 encryption model run on random data.
module tb_aes_decryption;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] key_byte = '0;
  logic [7:0] state_byte = '0;
  logic [7:0] state_out_byte;
  logic       load;
  logic       ready;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned ecnt = 0;
  logic [7:0]  sbox_t [256];

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] rk10;
    int unsigned  nready;
    int unsigned  e_edge;
    int unsigned  rise;
    int unsigned  fall;
    int unsigned  load_edge;
    int unsigned  overlap;
    logic         timeout;
  } res_t;

  always #5 clk = ~clk;

  aes_decryption dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .key_byte       (key_byte),
    .state_byte     (state_byte),
    .state_out_byte (state_out_byte),
    .load           (load),
    .ready          (ready)
  );

  // ---------------- reference model: forward AES-128 ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int unsigned x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int unsigned y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int unsigned i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int unsigned i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int unsigned i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int unsigned rnd = 1; rnd <= 10; rnd++) begin
      for (int unsigned i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int unsigned c = 0; c < 4; c++)
        for (int unsigned r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int unsigned c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int unsigned i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- block driver ----------------
  task automatic run_block(input logic [127:0] key, input logic [127:0] ct,
                           input int unsigned dis_pct, input int unsigned abort_after,
                           output res_t r);
    int unsigned idx;
    int unsigned budget;
    logic        ld;
    logic        en;
    logic        done;
    idx = 0; budget = 0; done = 1'b0;
    r.pt = '0; r.rk10 = '0; r.nready = 0; r.e_edge = 0; r.rise = 0; r.fall = 0;
    r.load_edge = 0; r.overlap = 0; r.timeout = 1'b0;
    while (!done) begin
      @(negedge clk);
      ld = load;
      en = ($urandom_range(99) >= dis_pct);
      enable = en;
      if (ld && idx < 16) begin
        key_byte   = key[127-8*idx -: 8];
        state_byte = ct[8*idx +: 8];
      end else begin
        key_byte   = 8'($urandom);
        state_byte = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (load && ready) r.overlap++;
      if (en) begin
        ecnt++;
        if (ld && idx < 16) begin
          idx++;
          if (idx == 16) r.e_edge = ecnt;
        end
        if (!ld && load && r.load_edge == 0) r.load_edge = ecnt;
        if (r.e_edge != 0 && ecnt == r.e_edge + 10) r.rk10 = dut.rk_q[10];
        if (ready) begin
          if (r.nready == 0) r.rise = ecnt;
          if (r.nready < 16) r.pt[127-8*r.nready -: 8] = state_out_byte;
          r.nready++;
        end else if (r.nready > 0) begin
          r.fall = ecnt;
          done = 1'b1;
        end
        if (abort_after != 0 && r.e_edge != 0 && ecnt == r.e_edge + abort_after) done = 1'b1;
      end
      budget++;
      if (budget > 3000) begin
        r.timeout = 1'b1;
        done = 1'b1;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      key_byte = 8'($urandom);
      state_byte = 8'($urandom);
    end
    checks++; if (state_out_byte !== 8'h00) begin failures++; $display("FAIL reset_out: got %h expected 00", state_out_byte); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load: got %b expected 0", load); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fips_c1();
    res_t r;
    run_block(KEY_C1, CT_C1, 0, 0, r);
    checks++; if (r.timeout) begin failures++; $display("FAIL c1_timeout: got 1 expected 0"); end
    checks++; if (r.pt !== PT_C1) begin failures++; $display("FAIL c1_pt: got %h expected %h", r.pt, PT_C1); end
    checks++; if (r.nready != 16) begin failures++; $display("FAIL c1_ready_cycles: got %0d expected 16", r.nready); end
    checks++; if (r.rise != r.e_edge + 21) begin failures++; $display("FAIL c1_ready_rise: got E+%0d expected E+21", r.rise - r.e_edge); end
    checks++; if (r.fall != r.e_edge + 37) begin failures++; $display("FAIL c1_ready_fall: got E+%0d expected E+37", r.fall - r.e_edge); end
    checks++; if (r.overlap != 0) begin failures++; $display("FAIL c1_load_ready_overlap: got %0d expected 0", r.overlap); end
  endtask

  task automatic test_fips_b_rk();
    res_t r;
    run_block(KEY_B, CT_B, 0, 0, r);
    checks++; if (r.timeout) begin failures++; $display("FAIL b_timeout: got 1 expected 0"); end
    checks++; if (r.rk10 !== RK10_B) begin failures++; $display("FAIL b_rk10: got %h expected %h", r.rk10, RK10_B); end
    checks++; if (r.pt !== PT_B) begin failures++; $display("FAIL b_pt: got %h expected %h", r.pt, PT_B); end
  endtask

  task automatic test_random_enable();
    res_t r;
    logic [127:0] key, pt, ct;
    run_block(KEY_C1, CT_C1, 30, 0, r);
    checks++; if (r.pt !== PT_C1 || r.timeout) begin failures++; $display("FAIL stall_c1_pt: got %h expected %h", r.pt, PT_C1); end
    checks++; if (r.nready != 16) begin failures++; $display("FAIL stall_c1_ready_cycles: got %0d expected 16", r.nready); end
    for (int unsigned n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ct  = encrypt(key, pt);
      run_block(key, ct, (n == 0) ? 0 : 30, 0, r);
      checks++; if (r.pt !== pt || r.timeout) begin failures++; $display("FAIL rand_pt[%0d]: got %h expected %h", n, r.pt, pt); end
      checks++; if (r.nready != 16) begin failures++; $display("FAIL rand_ready_cycles[%0d]: got %0d expected 16", n, r.nready); end
      checks++; if (r.overlap != 0) begin failures++; $display("FAIL rand_overlap[%0d]: got %0d expected 0", n, r.overlap); end
    end
  endtask

  task automatic test_reset_mid_dec();
    res_t r;
    run_block(KEY_C1, CT_C1, 0, 0, r);
    run_block(KEY_B, CT_B, 0, 15, r);
    checks++; if (r.timeout) begin failures++; $display("FAIL middec_timeout: got 1 expected 0"); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (state_out_byte !== 8'h00) begin failures++; $display("FAIL middec_out: got %h expected 00", state_out_byte); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL middec_load: got %b expected 0", load); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL middec_ready: got %b expected 0", ready); end
    checks++; if (dut.rk_q[10] !== 128'h0) begin failures++; $display("FAIL middec_rk10_cleared: got %h expected 0", dut.rk_q[10]); end
    @(negedge clk);
    rst = 1'b1;
    run_block(KEY_C1, CT_C1, 0, 0, r);
    checks++; if (r.pt !== PT_C1 || r.timeout) begin failures++; $display("FAIL middec_reload_pt: got %h expected %h", r.pt, PT_C1); end
    checks++; if (r.nready != 16) begin failures++; $display("FAIL middec_reload_ready_cycles: got %0d expected 16", r.nready); end
  endtask

  task automatic test_back_to_back();
    res_t r1, r2;
    run_block(KEY_C1, CT_C1, 0, 0, r1);
    run_block(KEY_B, CT_B, 0, 0, r2);
    checks++; if (r1.pt !== PT_C1 || r1.timeout) begin failures++; $display("FAIL b2b_pt0: got %h expected %h", r1.pt, PT_C1); end
    checks++; if (r2.pt !== PT_B || r2.timeout) begin failures++; $display("FAIL b2b_pt1: got %h expected %h", r2.pt, PT_B); end
    checks++; if (r2.load_edge != r1.fall + 1) begin failures++; $display("FAIL b2b_load_after_ready: got %0d expected %0d", r2.load_edge, r1.fall + 1); end
    checks++; if (r2.load_edge - r1.load_edge != 54) begin failures++; $display("FAIL b2b_period: got %0d expected 54", r2.load_edge - r1.load_edge); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b_rk();
    test_random_enable();
    test_reset_mid_dec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
